// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge.
package sram_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Request captured at acceptance; the core may change its inputs afterwards.
  typedef struct packed {
    src_e              src;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 single-beat master bus between the bridge and the SoC crossbar.
interface sram_axi_bridge_if;
  import sram_axi_bridge_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits; size 3 behaves as word.
module sram_axi_bridge_wstrb_gen
  import sram_axi_bridge_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  output logic [STRB_W-1:0] wstrb_c
);

  always_comb begin
    wstrb_c = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb_c = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb_c = 4'b0011 << {addr_lo[1], 1'b0};
      default:   wstrb_c = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the core's inst/data SRAM-like ports onto one AXI3 master,
// one single-beat transaction in flight, data side first.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [ID_W-1:0] ID_INST = 4'd0,
  parameter logic [ID_W-1:0] ID_DATA = 4'd1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  sram_axi_bridge_if.master axi
);

  state_e            state;
  req_t              req;
  req_t              grant_req_c;
  logic              aw_done;
  logic              w_done;
  logic              idle_c;
  logic              grant_data_c;
  logic              grant_inst_c;
  logic              aw_hs_c;
  logic              w_hs_c;
  logic              resp_c;
  logic [ID_W-1:0]   id_c;
  logic [STRB_W-1:0] wstrb_c;
  logic              unused_c;

  assign idle_c       = (state == IDLE) && !rst;
  assign grant_data_c = idle_c && data_req;
  assign grant_inst_c = idle_c && inst_req && !data_req;
  assign aw_hs_c      = axi.awvalid && axi.awready;
  assign w_hs_c       = axi.wvalid && axi.wready;
  assign resp_c       = ((state == RD_DATA) && axi.rvalid) ||
                        ((state == WR_RESP) && axi.bvalid);

  // Request presented by the winning side this cycle.
  always_comb begin
    grant_req_c = '0;
    if (data_req) begin
      grant_req_c.src   = SRC_DATA;
      grant_req_c.wr    = data_wr;
      grant_req_c.size  = data_size;
      grant_req_c.addr  = data_addr;
      grant_req_c.wdata = data_wdata;
    end else begin
      grant_req_c.src   = SRC_INST;
      grant_req_c.wr    = inst_wr;
      grant_req_c.size  = inst_size;
      grant_req_c.addr  = inst_addr;
      grant_req_c.wdata = inst_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data_c || grant_inst_c) begin
            req     <= grant_req_c;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= grant_req_c.wr ? WR_REQ : RD_ADDR;
          end
        end
        RD_ADDR: if (axi.arready) state <= RD_DATA;
        RD_DATA: if (axi.rvalid)  state <= IDLE;
        WR_REQ: begin
          // AW and W complete independently, possibly in the same cycle.
          aw_done <= aw_done || aw_hs_c;
          w_done  <= w_done  || w_hs_c;
          if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) state <= WR_RESP;
        end
        WR_RESP: if (axi.bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sram_axi_bridge_wstrb_gen u_wstrb_gen (
    .size    (req.size),
    .addr_lo (req.addr[1:0]),
    .wstrb_c (wstrb_c)
  );

  assign id_c = (req.src == SRC_DATA) ? ID_DATA : ID_INST;

  assign axi.arid    = id_c;
  assign axi.araddr  = req.addr;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, req.size};
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state == RD_ADDR);
  assign axi.rready  = (state == RD_DATA);

  assign axi.awid    = id_c;
  assign axi.awaddr  = req.addr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = {1'b0, req.size};
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = (state == WR_REQ) && !aw_done;

  assign axi.wid     = id_c;
  assign axi.wdata   = req.wdata;
  assign axi.wstrb   = wstrb_c;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state == WR_REQ) && !w_done;
  assign axi.bready  = (state == WR_RESP);

  assign inst_addr_ok = grant_inst_c;
  assign data_addr_ok = grant_data_c;
  assign inst_data_ok = resp_c && (req.src == SRC_INST);
  assign data_data_ok = resp_c && (req.src == SRC_DATA);
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  // Response IDs and error codes carry no information for a single in-order transaction.
  assign unused_c = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule
